picorv32_mem_responder: RTL and testbench
=========================================

// Module: picorv32_mem_responder
// PURPOSE
//  Slave/responder end of the picorv32 native memory bus (mem_valid/mem_ready handshake).
//  Serves instruction fetches, loads and byte-strobed stores from a local word-addressed RAM.
//  Inserts a programmable number of wait states so core fetch/ldmem/stmem stalls can be exercised.
//  Sits between the core's memory interface and on-chip RAM, in place of the AXI bridge.
// PARAMETERS
//  MEM_WORDS    1024          RAM depth in 32-bit words; power of 2, 16..65536
//  ADDR_BASE    32'h0000_0000 byte address of word 0; 4*MEM_WORDS aligned
//  WAIT_STATES  1             extra cycles before mem_ready, 0..15
// PORTS
//  clk        in   1   clock, all state on rising edge
//  resetn     in   1   asynchronous active-low reset
//  mem_valid  in   1   request valid; held by core until mem_ready seen
//  mem_instr  in   1   request is an instruction fetch (status only, same timing)
//  mem_addr   in   32  byte address; bits [1:0] ignored
//  mem_wdata  in   32  store data
//  mem_wstrb  in   4   byte enables; 4'b0000 = read
//  mem_ready  out  1   one-cycle completion pulse
//  mem_rdata  out  32  read data, valid while mem_ready=1
//  mem_busy   out  1   1 whenever state != IDLE
//  buserr     out  1   one-cycle bus-error pulse coincident with mem_ready (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, wait counter=0, mem_ready=0, mem_rdata=0, buserr=0.
//   RAM contents are not reset. Deassertion takes effect at the next clk edge.
//  FSM states:
//   IDLE -> WAIT if mem_valid && WAIT_STATES!=0 (counter loads WAIT_STATES-1)
//   IDLE -> ACK  if mem_valid && WAIT_STATES==0
//   WAIT: counter decrements; -> ACK when counter==0 and mem_valid=1
//   ACK (mem_ready=1 for exactly one cycle) -> IDLE unconditionally
//  Latency: mem_ready is high in cycle N+WAIT_STATES+1 when mem_valid first rises in cycle N.
//  Request fields (addr/wdata/wstrb/instr) are sampled on the edge that enters ACK.
//   RAM access happens on that same edge:
//   - read: mem_rdata <= ram[idx]
//   - write: each byte b with mem_wstrb[b]=1 written; mem_rdata <= 0
//  idx = (mem_addr - ADDR_BASE) >> 2; in range iff ADDR_BASE <= mem_addr < ADDR_BASE+4*MEM_WORDS.
//  Write then read of the same word on back-to-back transactions returns the new data.
//  mem_rdata holds its value outside ACK; it is only meaningful while mem_ready=1.
//  mem_valid=1 sampled in ACK is ignored (core drops it after the ready edge). A request
//   that is still valid in the cycle after ACK starts a new transaction from IDLE.
//  mem_valid dropping while in WAIT (protocol violation): -> IDLE; no RAM write; no mem_ready.
//  mem_instr does not alter behaviour; a fetch with wstrb!=0 is still performed as a write.
//  Reset asserted mid-transaction: transaction abandoned; no partial write occurs unless its
//   ACK-entry edge has already happened.
// CONFIGURATION
//  Macro MEM_RESP_BUSERR_EN:
//   defined: out-of-range access still completes with mem_ready after normal latency;
//     buserr=1 in the same cycle; write suppressed; mem_rdata=32'h0000_0000.
//   undefined: no range check; idx truncated to log2(MEM_WORDS) bits (address aliases,
//     wraps modulo RAM size); buserr tied to 0.
// TESTING
//  1 WAIT_STATES=0: read addr 0x0 after preload 0x0000_0013
//     -> mem_ready 1 cycle after mem_valid; mem_rdata=0x0000_0013.
//  2 WAIT_STATES=3: store 0xA5A5_A5A5 wstrb=4'b1111 to 0x10
//     -> mem_ready in 4th cycle after mem_valid; mem_busy=1 for 4 cycles; readback=0xA5A5_A5A5.
//  3 Prior word 0x1122_3344 at 0x20; store wdata 0xFFEE_DDCC wstrb=4'b0101
//     -> readback 0x11EE_33CC.
//  4 Back-to-back: fetch 0x4 then load 0x8 with mem_valid re-asserted 1 cycle after ready
//     -> two single-cycle mem_ready pulses; no duplicate accept; correct data for each.
//  5 MEM_RESP_BUSERR_EN, MEM_WORDS=1024: write 0x1000 then read 0x1000
//     -> buserr=1 with mem_ready both times; read returns 0; RAM word 0 unchanged.
//     Without macro: the write aliases to word 0.
//  6 WAIT_STATES=5: resetn low for 1 cycle during WAIT of a store
//     -> mem_ready/buserr=0 immediately; target word unchanged; next request served normally.

Source files
------------

// File: rtl/picorv32_mem_responder.sv
// picorv32 native-bus responder: local word RAM with programmable wait states.
// Define MEM_RESP_BUSERR_EN to range-check addresses and flag out-of-range accesses on buserr.
module picorv32_mem_responder #(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_busy,
    output logic        buserr
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_buserr;
    logic [31:0] r_ram [MEM_WORDS];

    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_oor;
    logic          w_acc;
    logic          w_we;
    logic          w_unused;

    assign w_off = mem_addr - ADDR_BASE;
    assign w_idx = w_off[AW+1:2];

`ifdef MEM_RESP_BUSERR_EN
    // Addresses below ADDR_BASE wrap to a huge offset, so one compare covers both ends.
    assign w_oor = (w_off >= 32'(4 * MEM_WORDS));
`else
    assign w_oor = 1'b0;
`endif

    // Access strobe: true on the edge that moves the FSM into ACK.
    assign w_acc = resetn && mem_valid &&
                   (((r_state == S_IDLE) && (WAIT_STATES == 0)) ||
                    ((r_state == S_WAIT) && (r_cnt == 4'd0)));
    assign w_we  = w_acc && !w_oor && (mem_wstrb != 4'b0000);

    assign w_unused = ^{mem_instr, w_off};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_ready  <= 1'b0;
            r_rdata  <= 32'h0000_0000;
            r_buserr <= 1'b0;
        end else begin
            r_ready  <= 1'b0;
            r_buserr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_valid) begin
                        if (WAIT_STATES == 0) begin
                            r_state <= S_ACK;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!mem_valid) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_acc) begin
                r_ready  <= 1'b1;
                r_buserr <= w_oor;
                r_rdata  <= (w_oor || (mem_wstrb != 4'b0000)) ? 32'h0000_0000 : r_ram[w_idx];
            end
        end
    end

    // RAM contents survive reset, so the array lives in its own clock-only block.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) begin
                    r_ram[w_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign mem_busy  = (r_state != S_IDLE);
    assign buserr    = r_buserr;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed bench for picorv32_mem_responder: three instances with 0, 3 and 5 wait states.
module tb_picorv32_mem_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        v_valid [3];
    logic        v_instr [3];
    logic [31:0] v_addr  [3];
    logic [31:0] v_wdata [3];
    logic [3:0]  v_wstrb [3];
    logic        o_ready [3];
    logic [31:0] o_rdata [3];
    logic        o_busy  [3];
    logic        o_berr  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    picorv32_mem_responder #(.MEM_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .resetn(resetn), .mem_valid(v_valid[0]), .mem_instr(v_instr[0]),
        .mem_addr(v_addr[0]), .mem_wdata(v_wdata[0]), .mem_wstrb(v_wstrb[0]),
        .mem_ready(o_ready[0]), .mem_rdata(o_rdata[0]), .mem_busy(o_busy[0]), .buserr(o_berr[0]));

    picorv32_mem_responder #(.MEM_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .resetn(resetn), .mem_valid(v_valid[1]), .mem_instr(v_instr[1]),
        .mem_addr(v_addr[1]), .mem_wdata(v_wdata[1]), .mem_wstrb(v_wstrb[1]),
        .mem_ready(o_ready[1]), .mem_rdata(o_rdata[1]), .mem_busy(o_busy[1]), .buserr(o_berr[1]));

    picorv32_mem_responder #(.MEM_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_STATES(5)) u_ws5 (
        .clk(clk), .resetn(resetn), .mem_valid(v_valid[2]), .mem_instr(v_instr[2]),
        .mem_addr(v_addr[2]), .mem_wdata(v_wdata[2]), .mem_wstrb(v_wstrb[2]),
        .mem_ready(o_ready[2]), .mem_rdata(o_rdata[2]), .mem_busy(o_busy[2]), .buserr(o_berr[2]));

    // One core-style transaction; lat counts cycles after the cycle mem_valid rose (-1 = timeout).
    task automatic xfer(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic instr,
                        output logic [31:0] rdata, output int lat, output int busy_cyc,
                        output logic berr, output logic pulse_ok);
        rdata = 'x;
        berr = 1'bx;
        lat = -1;
        busy_cyc = 0;
        @(posedge clk);
        #1;
        v_valid[k] = 1'b1;
        v_addr[k]  = addr;
        v_wdata[k] = wdata;
        v_wstrb[k] = wstrb;
        v_instr[k] = instr;
        @(negedge clk);
        pulse_ok = !o_ready[k] && !o_busy[k];
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (o_busy[k]) busy_cyc++;
            if (o_ready[k]) begin
                lat = c;
                rdata = o_rdata[k];
                berr = o_berr[k];
                break;
            end
        end
        @(posedge clk);
        #1;
        v_valid[k] = 1'b0;
        v_wstrb[k] = 4'b0000;
        v_instr[k] = 1'b0;
        @(negedge clk);
        if (o_ready[k] || o_busy[k]) pulse_ok = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({o_ready[k], o_rdata[k], o_busy[k], o_berr[k]} !== 35'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got rdy=%b rdata=%h busy=%b berr=%b, want all 0",
                         k, o_ready[k], o_rdata[k], o_busy[k], o_berr[k]);
            end
        end
        resetn = 1'b1;
    endtask

    task automatic test_fetch_ws0();
        logic [31:0] rd; int lat; int bc; logic be; logic po;
        xfer(0, 32'h0, 32'h0000_0013, 4'b1111, 1'b0, rd, lat, bc, be, po);
        checks++;
        if (rd !== 32'h0 || lat !== 1) begin
            errors++;
            $display("FAIL ws0_preload: got rdata=%h lat=%0d, want rdata=0 lat=1", rd, lat);
        end
        xfer(0, 32'h0, 32'h0, 4'b0000, 1'b1, rd, lat, bc, be, po);
        checks++;
        if (rd !== 32'h0000_0013) begin
            errors++;
            $display("FAIL ws0_fetch_data: got %h want 00000013", rd);
        end
        checks++;
        if (lat !== 1 || bc !== 1 || po !== 1'b1 || be !== 1'b0) begin
            errors++;
            $display("FAIL ws0_fetch_timing: got lat=%0d busy=%0d pulse=%b berr=%b, want 1 1 1 0",
                     lat, bc, po, be);
        end
    endtask

    task automatic test_wait_store();
        logic [31:0] rd; int lat; int bc; logic be; logic po;
        xfer(1, 32'h10, 32'hA5A5_A5A5, 4'b1111, 1'b0, rd, lat, bc, be, po);
        checks++;
        if (lat !== 4 || bc !== 4 || po !== 1'b1) begin
            errors++;
            $display("FAIL ws3_store_timing: got lat=%0d busy=%0d pulse=%b, want 4 4 1", lat, bc, po);
        end
        xfer(1, 32'h10, 32'h0, 4'b0000, 1'b0, rd, lat, bc, be, po);
        checks++;
        if (rd !== 32'hA5A5_A5A5 || lat !== 4) begin
            errors++;
            $display("FAIL ws3_readback: got rdata=%h lat=%0d, want a5a5a5a5 4", rd, lat);
        end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] rd; int lat; int bc; logic be; logic po;
        xfer(1, 32'h20, 32'h1122_3344, 4'b1111, 1'b0, rd, lat, bc, be, po);
        xfer(1, 32'h20, 32'hFFEE_DDCC, 4'b0101, 1'b0, rd, lat, bc, be, po);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL strobe_write_rdata: got %h want 00000000", rd);
        end
        xfer(1, 32'h23, 32'h0, 4'b0000, 1'b0, rd, lat, bc, be, po);
        checks++;
        if (rd !== 32'h11EE_33CC) begin
            errors++;
            $display("FAIL strobe_readback: got %h want 11ee33cc", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat; int bc; logic be; logic po;
        xfer(0, 32'h4, 32'hCAFE_0001, 4'b1111, 1'b0, rd, lat, bc, be, po);
        xfer(0, 32'h8, 32'hBEEF_0002, 4'b1111, 1'b0, rd, lat, bc, be, po);
        xfer(0, 32'h4, 32'h0, 4'b0000, 1'b1, rd, lat, bc, be, po);
        checks++;
        if (rd !== 32'hCAFE_0001 || lat !== 1 || po !== 1'b1) begin
            errors++;
            $display("FAIL b2b_fetch: got rdata=%h lat=%0d pulse=%b, want cafe0001 1 1", rd, lat, po);
        end
        xfer(0, 32'h8, 32'h0, 4'b0000, 1'b0, rd, lat, bc, be, po);
        checks++;
        if (rd !== 32'hBEEF_0002 || lat !== 1 || po !== 1'b1) begin
            errors++;
            $display("FAIL b2b_load: got rdata=%h lat=%0d pulse=%b, want beef0002 1 1", rd, lat, po);
        end
    endtask

    task automatic test_protocol_drop();
        logic [31:0] rd; int lat; int bc; logic be; logic po; int nrdy;
        xfer(1, 32'h30, 32'h55AA_55AA, 4'b1111, 1'b0, rd, lat, bc, be, po);
        @(posedge clk);
        #1;
        v_valid[1] = 1'b1; v_addr[1] = 32'h30; v_wdata[1] = 32'hDEAD_BEEF; v_wstrb[1] = 4'b1111;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        v_valid[1] = 1'b0;
        nrdy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_ready[1]) nrdy++;
        end
        checks++;
        if (nrdy !== 0 || o_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL drop_no_ready: got ready_pulses=%0d busy=%b, want 0 0", nrdy, o_busy[1]);
        end
        v_wstrb[1] = 4'b0000;
        xfer(1, 32'h30, 32'h0, 4'b0000, 1'b0, rd, lat, bc, be, po);
        checks++;
        if (rd !== 32'h55AA_55AA) begin
            errors++;
            $display("FAIL drop_no_write: got %h want 55aa55aa", rd);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd; int lat; int bc; logic be; logic po;
        xfer(0, 32'h1000, 32'h9999_9999, 4'b1111, 1'b0, rd, lat, bc, be, po);
`ifdef MEM_RESP_BUSERR_EN
        checks++;
        if (be !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL oor_write: got berr=%b lat=%0d, want 1 1", be, lat);
        end
        xfer(0, 32'h1000, 32'h0, 4'b0000, 1'b0, rd, lat, bc, be, po);
        checks++;
        if (be !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL oor_read: got berr=%b rdata=%h, want 1 00000000", be, rd);
        end
        xfer(0, 32'h0, 32'h0, 4'b0000, 1'b0, rd, lat, bc, be, po);
        checks++;
        if (rd !== 32'h0000_0013 || be !== 1'b0) begin
            errors++;
            $display("FAIL oor_word0_kept: got rdata=%h berr=%b, want 00000013 0", rd, be);
        end
`else
        checks++;
        if (be !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL alias_write: got berr=%b lat=%0d, want 0 1", be, lat);
        end
        xfer(0, 32'h0, 32'h0, 4'b0000, 1'b0, rd, lat, bc, be, po);
        checks++;
        if (rd !== 32'h9999_9999 || be !== 1'b0) begin
            errors++;
            $display("FAIL alias_word0: got rdata=%h berr=%b, want 99999999 0", rd, be);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; int bc; logic be; logic po;
        xfer(2, 32'h40, 32'h1234_5678, 4'b1111, 1'b0, rd, lat, bc, be, po);
        checks++;
        if (lat !== 6 || bc !== 6) begin
            errors++;
            $display("FAIL ws5_timing: got lat=%0d busy=%0d, want 6 6", lat, bc);
        end
        @(posedge clk);
        #1;
        v_valid[2] = 1'b1; v_addr[2] = 32'h40; v_wdata[2] = 32'h0BAD_F00D; v_wstrb[2] = 4'b1111;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (o_ready[2] !== 1'b0 || o_berr[2] !== 1'b0 || o_busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got rdy=%b berr=%b busy=%b, want 0 0 0",
                     o_ready[2], o_berr[2], o_busy[2]);
        end
        @(negedge clk);
        resetn = 1'b1;
        v_valid[2] = 1'b0;
        v_wstrb[2] = 4'b0000;
        xfer(2, 32'h40, 32'h0, 4'b0000, 1'b0, rd, lat, bc, be, po);
        checks++;
        if (rd !== 32'h1234_5678 || lat !== 6 || po !== 1'b1) begin
            errors++;
            $display("FAIL midreset_recover: got rdata=%h lat=%0d pulse=%b, want 12345678 6 1",
                     rd, lat, po);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            v_valid[k] = 1'b0;
            v_instr[k] = 1'b0;
            v_addr[k]  = 32'h0;
            v_wdata[k] = 32'h0;
            v_wstrb[k] = 4'b0000;
        end
        test_reset();
        test_fetch_ws0();
        test_wait_store();
        test_byte_strobe();
        test_back_to_back();
        test_protocol_drop();
        test_range();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
